// File: rtl/vscale_htif_pcr_master.sv
// Host-side initiator for the per-core HTIF PCR (CSR) request/response interface.
// Accepts one CSR read/write command at a time and forwards it to the selected core.
// It then waits for that core's response and returns the data, or an error on timeout
// or when the core index is out of range.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   cmd_*                 host command channel (valid/ready, core, rw, addr, wdata)
//   rsp_*                 host result channel (valid/ready, rdata, error)
//   htif_pcr_req_*        one-hot request valid per core, shared rw/addr/data
//   htif_pcr_resp_*       per-core response valid/data, broadcast response ready
module vscale_htif_pcr_master #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned CORE_IDX_WIDTH = 1,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned HTIF_PCR_WIDTH = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [CORE_IDX_WIDTH-1:0]           cmd_core,
  input  logic                                cmd_rw,
  input  logic [CSR_ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [HTIF_PCR_WIDTH-1:0]           cmd_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [HTIF_PCR_WIDTH-1:0]           rsp_rdata,
  output logic                                rsp_error,
  output logic [NUM_CORES-1:0]                htif_pcr_req_valid,
  input  logic [NUM_CORES-1:0]                htif_pcr_req_ready,
  output logic                                htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0]           htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0]           htif_pcr_req_data,
  input  logic [NUM_CORES-1:0]                htif_pcr_resp_valid,
  output logic                                htif_pcr_resp_ready,
  input  logic [NUM_CORES*HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CORE_IDX_WIDTH-1:0] core_q, core_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      rw_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_d;
  logic [HTIF_PCR_WIDTH-1:0] data_d;
  logic [HTIF_PCR_WIDTH-1:0] rdata_d;
  logic                      error_d;

  logic                      handshake_c;
  logic                      sel_resp_valid_c;
  logic [HTIF_PCR_WIDTH-1:0] sel_resp_data_c;
  logic                      expired_c;
  logic [CNT_W-1:0]          cnt_inc_c;

  // One-hot decode of a core index; out-of-range indices decode to zero.
  function automatic logic [NUM_CORES-1:0] core_onehot(input logic [CORE_IDX_WIDTH-1:0] c);
    core_onehot = (32'(c) < NUM_CORES) ? (NUM_CORES'(1) << c) : '0;
  endfunction

  // Selected-core views of the request/response channels.
  always_comb begin
    handshake_c      = |(htif_pcr_req_valid & htif_pcr_req_ready);
    sel_resp_valid_c = |(htif_pcr_resp_valid & core_onehot(core_q));
    sel_resp_data_c  = HTIF_PCR_WIDTH'(htif_pcr_resp_data >> (32'(core_q) * HTIF_PCR_WIDTH));
    // Compare with >= so a handshake landing exactly on the last cycle still
    // leaves the RESP phase bounded once the counter has moved past it.
    expired_c        = (cnt_q >= CNT_LAST);
    cnt_inc_c        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    cnt_d   = cnt_q;
    rw_d    = htif_pcr_req_rw;
    addr_d  = htif_pcr_req_addr;
    data_d  = htif_pcr_req_data;
    rdata_d = rsp_rdata;
    error_d = rsp_error;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          core_d = cmd_core;
          rw_d   = cmd_rw;
          addr_d = cmd_addr;
          data_d = cmd_wdata;
          cnt_d  = '0;
          if (32'(cmd_core) >= NUM_CORES) begin
            state_d = DONE;
            rdata_d = '0;
            error_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc_c;
        if (handshake_c) begin
          state_d = RESP;
        end else if (expired_c) begin
          state_d = DONE;
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      RESP: begin
        cnt_d = cnt_inc_c;
        if (sel_resp_valid_c) begin
          state_d = DONE;
          rdata_d = sel_resp_data_c;
          error_d = 1'b0;
        end else if (expired_c) begin
          state_d = DONE;
          rdata_d = '0;
          error_d = 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; handshake outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q             <= IDLE;
      core_q              <= '0;
      cnt_q               <= '0;
      cmd_ready           <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_error           <= 1'b0;
      htif_pcr_req_valid  <= '0;
      htif_pcr_req_rw     <= 1'b0;
      htif_pcr_req_addr   <= '0;
      htif_pcr_req_data   <= '0;
      htif_pcr_resp_ready <= 1'b0;
    end else begin
      state_q             <= state_d;
      core_q              <= core_d;
      cnt_q               <= cnt_d;
      cmd_ready           <= (state_d == IDLE);
      rsp_valid           <= (state_d == DONE);
      rsp_rdata           <= rdata_d;
      rsp_error           <= error_d;
      htif_pcr_req_valid  <= (state_d == REQ) ? core_onehot(core_d) : '0;
      htif_pcr_req_rw     <= rw_d;
      htif_pcr_req_addr   <= addr_d;
      htif_pcr_req_data   <= data_d;
      htif_pcr_resp_ready <= (state_d == RESP);
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_master.sv
// Self-checking bench for vscale_htif_pcr_master (3 cores, 2-bit core index, 16-cycle timeout).
// Each transaction's outcome (phase lengths, latency, error, data) is predicted from
// the protocol rules. The prediction uses the ready/response delays the bench itself applies.
module tb_vscale_htif_pcr_master;
  localparam int NC  = 3;
  localparam int CIW = 2;
  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int TO  = 16;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CIW-1:0]    cmd_core;
  logic              cmd_rw;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error;
  logic [NC-1:0]     req_valid;
  logic [NC-1:0]     req_ready;
  logic              req_rw;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_data;
  logic [NC-1:0]     resp_valid;
  logic              resp_ready;
  logic [NC*DW-1:0]  resp_data;

  int checks = 0;
  int errors = 0;

  vscale_htif_pcr_master #(
    .NUM_CORES(NC), .CORE_IDX_WIDTH(CIW), .CSR_ADDR_WIDTH(AW),
    .HTIF_PCR_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_core(cmd_core),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .htif_pcr_req_valid(req_valid), .htif_pcr_req_ready(req_ready),
    .htif_pcr_req_rw(req_rw), .htif_pcr_req_addr(req_addr), .htif_pcr_req_data(req_data),
    .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(resp_ready),
    .htif_pcr_resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_data();
    resp_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // One complete command: d = cycles the target holds req_ready low,
  // r = cycles after the handshake before the target responds, h = rsp_ready delay.
  task automatic run_txn(input int core, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int d, input int r,
                         input logic [DW-1:0] rd, input int h);
    int            reqc, respc, lim, lat;
    logic          err;
    logic [DW-1:0] exp_data;
    logic [NC-1:0] oh;
    logic [NC*DW-1:0] m;
    bit            valid;

    valid = (core < NC);
    oh    = valid ? NC'(1 << core) : NC'(0);
    if (!valid) begin
      reqc = 0; respc = 0; err = 1'b1;
    end else if (d + 1 > TO) begin
      reqc = TO; respc = 0; err = 1'b1;
    end else begin
      reqc = d + 1;
      lim  = (TO - reqc > 1) ? TO - reqc : 1;
      if (r + 1 <= lim) begin respc = r + 1; err = 1'b0; end
      else begin respc = lim; err = 1'b1; end
    end
    lat      = reqc + respc + 1;
    exp_data = err ? '0 : rd;

    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid  = 1'b1;
    cmd_core   = CIW'(core);
    cmd_rw     = rw;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    req_ready  = NC'($urandom);
    resp_valid = NC'($urandom);
    noise_data();
    tick();
    cmd_valid = 1'b0;
    cmd_core  = CIW'($urandom);
    cmd_rw    = ~rw;
    cmd_addr  = AW'($urandom);
    cmd_wdata = {$urandom, $urandom};

    for (int c = 1; c <= lat + h; c++) begin
      chk("req_valid", 64'(req_valid), (c <= reqc) ? 64'(oh) : 64'(0));
      chk("resp_ready", 64'(resp_ready), 64'(c > reqc && c <= reqc + respc));
      chk("rsp_valid", 64'(rsp_valid), 64'(c >= lat));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
      if (c <= reqc) begin
        chk("req_rw", 64'(req_rw), 64'(rw));
        chk("req_addr", 64'(req_addr), 64'(addr));
        chk("req_data", req_data, wdata);
      end
      if (c >= lat) begin
        chk("rsp_rdata", rsp_rdata, exp_data);
        chk("rsp_error", 64'(rsp_error), 64'(err));
      end
      // Inputs for this cycle: non-target cores toggle freely.
      req_ready = (NC'($urandom) & ~oh) | ((c >= d + 1) ? oh : NC'(0));
      if (c <= reqc)
        resp_valid = NC'($urandom);
      else
        resp_valid = (NC'($urandom) & ~oh) | ((c >= reqc + r + 1) ? oh : NC'(0));
      noise_data();
      if (valid && c > reqc) begin
        m = (NC*DW)'({DW{1'b1}}) << (core * DW);
        resp_data = (resp_data & ~m) | (((NC*DW)'(rd)) << (core * DW));
      end
      rsp_ready = (c < lat) ? 1'($urandom) : (c == lat + h);
      tick();
    end
    chk("rsp_valid_clear", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_back", 64'(cmd_ready), 64'(1));
    rsp_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    cmd_valid = 1'b0; cmd_core = '0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; req_ready = '0; resp_valid = '0; resp_data = '0;
    repeat (3) tick();

    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst_rsp_rdata", rsp_rdata, 64'(0));
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_resp_ready", 64'(resp_ready), 64'(0));
    reset = 1'b1;
    repeat (2) tick();

    // Directed cases.
    run_txn(0, 1'b0, 12'h780, 64'h0, 0, 0, 64'h1234, 0);
    run_txn(1, 1'b1, 12'h3a0, 64'hDEAD, 5, 0, 64'hC0FFEE, 1);
    run_txn(1, 1'b0, 12'h100, 64'h0, 0, 2, 64'h55, 0);
    run_txn(2, 1'b0, 12'h200, 64'h9, 30, 0, 64'h77, 2);
    run_txn(3, 1'b1, 12'h321, 64'h42, 0, 0, 64'h99, 0);
    run_txn(0, 1'b0, 12'h010, 64'h1, 2, 20, 64'hABC, 1);
    run_txn(2, 1'b1, 12'h011, 64'h2, 3, 11, 64'h1111_2222_3333_4444, 0);
    run_txn(2, 1'b0, 12'h012, 64'h3, 3, 12, 64'h5555, 0);
    run_txn(1, 1'b0, 12'h013, 64'h4, 15, 0, 64'h6666, 0);
    run_txn(1, 1'b0, 12'h014, 64'h5, 15, 1, 64'h7777, 0);
    run_txn(0, 1'b1, 12'h015, 64'h6, 16, 0, 64'h8888, 0);

    // Reset while waiting in RESP.
    chk("rst2_cmd_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_core = 2'd2; cmd_rw = 1'b1; cmd_addr = 12'h123;
    cmd_wdata = 64'hA5A5; req_ready = '0; resp_valid = '0;
    tick();
    cmd_valid = 1'b0; req_ready = 3'b100;
    tick();
    chk("rst2_resp_ready_pre", 64'(resp_ready), 64'(1));
    req_ready = '0; reset = 1'b0;
    tick();
    chk("rst2_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst2_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst2_rsp_error", 64'(rsp_error), 64'(0));
    chk("rst2_rsp_rdata", rsp_rdata, 64'(0));
    chk("rst2_req_valid", 64'(req_valid), 64'(0));
    chk("rst2_req_rw", 64'(req_rw), 64'(0));
    chk("rst2_req_addr", 64'(req_addr), 64'(0));
    chk("rst2_req_data", req_data, 64'(0));
    chk("rst2_resp_ready", 64'(resp_ready), 64'(0));
    reset = 1'b1; resp_valid = 3'b100; resp_data = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("late_req_valid", 64'(req_valid), 64'(0));
    end
    resp_valid = '0;
    run_txn(2, 1'b0, 12'h456, 64'h0, 1, 1, 64'hFEED_BEEF, 0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      int core, d, r, h;
      core = int'($urandom_range(0, 3));
      d    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 18)) : int'($urandom_range(0, 3));
      r    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 18))  : int'($urandom_range(0, 3));
      h    = int'($urandom_range(0, 2));
      run_txn(core, 1'($urandom), AW'($urandom), {$urandom, $urandom}, d, r,
              {$urandom, $urandom}, h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
